// File: rtl/wr_uart_logger_pkg.sv
// Shared types and constants for the CPU write-event UART logger.
`default_nettype none

package wr_uart_logger_pkg;

   localparam logic [3:0] HDR_NIBBLE    = 4'hA;
   localparam int         DATA_BITS     = 8;
   localparam int         BITS_PER_BYTE = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/wr_event_fifo.sv
// Synchronous FIFO for captured write events; async active-low reset.
`default_nettype none

module wr_event_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_en;
   logic             rd_en;

   // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/wr_uart_logger.sv
// Captures CPU write events into a FIFO and streams each as a two-byte UART frame.
`default_nettype none

module wr_uart_logger
   import wr_uart_logger_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 8,
   parameter int ADDR_W       = 4,
   parameter int DATA_W       = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_wr_valid,
   input  logic [ADDR_W-1:0] i_wr_add,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_tx,
   output logic              o_busy,
   output logic              o_full,
   output logic              o_overflow
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CNT_F = $clog2(FIFO_DEPTH) + 1;

   state_t                     state, state_nx;
   logic [CNT_W-1:0]           baud_cnt, baud_nx;
   logic [2:0]                 bit_idx, bit_nx;
   logic                       byte_idx, byte_nx;
   logic [7:0]                 shreg, shreg_nx;
   logic [7:0]                 data_byte, data_nx;
   logic                       overflow;

   logic [ADDR_W+DATA_W-1:0]   head;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [CNT_F-1:0]           fifo_count;
   logic                       pop;
   logic                       baud_done;

   assign pop       = (state == IDLE) && !fifo_empty;
   assign baud_done = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

   wr_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ADDR_W + DATA_W)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_reset),
      .push  (i_wr_valid),
      .pop   (pop),
      .wdata ({i_wr_add, i_wr_data}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         byte_idx  <= 1'b0;
         shreg     <= '0;
         data_byte <= '0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_nx;
         baud_cnt  <= baud_nx;
         bit_idx   <= bit_nx;
         byte_idx  <= byte_nx;
         shreg     <= shreg_nx;
         data_byte <= data_nx;
         if (i_wr_valid && fifo_full && !pop) overflow <= 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      baud_nx  = baud_cnt;
      bit_nx   = bit_idx;
      byte_nx  = byte_idx;
      shreg_nx = shreg;
      data_nx  = data_byte;
      o_tx     = 1'b1;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_nx = START;
               baud_nx  = '0;
               bit_nx   = '0;
               byte_nx  = 1'b0;
               shreg_nx = 8'({HDR_NIBBLE, head[DATA_W +: ADDR_W]});
               data_nx  = 8'(head[DATA_W-1:0]);
            end
         end
         START: begin
            o_tx = 1'b0;
            if (baud_done) begin
               baud_nx  = '0;
               state_nx = DATA;
            end else begin
               baud_nx = baud_cnt + CNT_W'(1);
            end
         end
         DATA: begin
            o_tx = shreg[0];
            if (baud_done) begin
               baud_nx  = '0;
               shreg_nx = shreg >> 1;
               bit_nx   = bit_idx + 3'd1;
               if (bit_idx == 3'(DATA_BITS - 1)) state_nx = STOP;
            end else begin
               baud_nx = baud_cnt + CNT_W'(1);
            end
         end
         STOP: begin
            // Byte 1 follows byte 0's stop bit with no idle gap.
            if (baud_done) begin
               baud_nx = '0;
               if (!byte_idx) begin
                  byte_nx  = 1'b1;
                  shreg_nx = data_byte;
                  state_nx = START;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               baud_nx = baud_cnt + CNT_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign o_busy     = (state != IDLE);
   assign o_full     = (fifo_count == CNT_F'(FIFO_DEPTH));
   assign o_overflow = overflow;

endmodule

`default_nettype wire

// File: tb/tb_wr_uart_logger.sv
// Directed self-checking bench for wr_uart_logger with a free-running UART frame monitor.
`default_nettype none

module tb_wr_uart_logger;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_valid = 1'b0;
   logic [3:0] wr_add = '0;
   logic [7:0] wr_data = '0;
   logic       tx, busy, full, overflow;

   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;
   int frame_err = 0;
   logic [7:0] byte_q [$];
   int         start_q [$];

   wr_uart_logger #(
      .CLKS_PER_BIT (4),
      .FIFO_DEPTH   (8),
      .ADDR_W       (4),
      .DATA_W       (8)
   ) dut (
      .i_clk      (clk),
      .i_reset    (rst_n),
      .i_wr_valid (wr_valid),
      .i_wr_add   (wr_add),
      .i_wr_data  (wr_data),
      .o_tx       (tx),
      .o_busy     (busy),
      .o_full     (full),
      .o_overflow (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Samples each bit mid-cell (cycle 2 of 4); frames cut by reset are discarded.
   initial begin
      logic [9:0] bits;
      int         st;
      bit         ok;
      forever begin
         @(negedge clk);
         if (rst_n && tx == 1'b0) begin
            st = cyc;
            ok = 1'b1;
            for (int k = 0; k < 10; k++) begin
               repeat ((k == 0) ? 2 : 4) @(negedge clk);
               if (!rst_n) ok = 1'b0;
               bits[k] = tx;
            end
            if (ok) begin
               byte_q.push_back(bits[8:1]);
               start_q.push_back(st);
               if (bits[0] != 1'b0 || bits[9] != 1'b1) frame_err++;
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      byte_q.delete();
      start_q.delete();
   endtask

   // Strobes edges 0..8 with addr=i, data=0x10+i; returns at the negedge after edge 8.
   task automatic fill9();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         wr_valid = 1'b1;
         wr_add   = 4'(i);
         wr_data  = 8'(8'h10 + i);
      end
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic wait_bytes(input int n);
      for (int t = 0; t < 4000 && byte_q.size() < n; t++) @(negedge clk);
      chk("byte_count", byte_q.size(), n);
   endtask

   task automatic chk_fill_bytes(input string tag);
      for (int i = 0; i < 9 && 2*i+1 < byte_q.size(); i++) begin
         chk({tag, "_hdr"},  byte_q[2*i],   8'(8'hA0 + i));
         chk({tag, "_data"}, byte_q[2*i+1], 8'(8'h10 + i));
      end
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_full", full, 0);
      chk("rst_ovf", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_count", dut.fifo_count, 0);

      // Single event: addr=3 data=5C strobed at edge 0
      byte_q.delete(); start_q.delete();
      wr_valid = 1'b1; wr_add = 4'd3; wr_data = 8'h5C;
      @(negedge clk);
      wr_valid = 1'b0;
      chk("s1_tx_e0", tx, 1);
      @(negedge clk);
      chk("s1_tx_e1", tx, 0);
      chk("s1_busy_e1", busy, 1);
      repeat (79) @(negedge clk);
      chk("s1_busy_e80", busy, 1);
      chk("s1_tx_e80", tx, 1);
      @(negedge clk);
      chk("s1_busy_e81", busy, 0);
      chk("s1_tx_e81", tx, 1);
      chk("s1_nbytes", byte_q.size(), 2);
      if (byte_q.size() >= 2) begin
         chk("s1_byte0", byte_q[0], 8'hA3);
         chk("s1_byte1", byte_q[1], 8'h5C);
         chk("s1_gap", start_q[1] - start_q[0], 40);
      end

      // Fill without loss, then overflow on a 10th strobe
      byte_q.delete(); start_q.delete();
      repeat (3) @(negedge clk);
      fill9();
      chk("s2_count_e8", dut.fifo_count, 8);
      chk("s2_full_e8", full, 1);
      chk("s2_ovf_e8", overflow, 0);
      wr_valid = 1'b1; wr_add = 4'hF; wr_data = 8'hEE;
      @(negedge clk);
      wr_valid = 1'b0;
      chk("s3_count_e9", dut.fifo_count, 8);
      @(negedge clk);
      chk("s3_ovf_e10", overflow, 1);
      wait_bytes(18);
      chk_fill_bytes("s2");
      for (int k = 0; k < 8 && 2*k+2 < start_q.size(); k++) begin
         chk("s6_byte_gap", start_q[2*k+1] - start_q[2*k], 40);
         chk("s6_event_gap", start_q[2*k+2] - start_q[2*k], 81);
      end
      repeat (200) @(negedge clk);
      chk("s3_no_10th", byte_q.size(), 18);
      chk("s3_ovf_sticky", overflow, 1);
      chk("s3_full_drained", full, 0);

      // Push coincides with the IDLE pop edge while holding 8 entries
      do_reset();
      fill9();
      repeat (73) @(negedge clk);
      chk("s4_idle_e81", busy, 0);
      chk("s4_count_e81", dut.fifo_count, 8);
      wr_valid = 1'b1; wr_add = 4'd9; wr_data = 8'h99;
      @(negedge clk);
      wr_valid = 1'b0;
      chk("s4_count_e82", dut.fifo_count, 8);
      chk("s4_full_e82", full, 1);
      chk("s4_busy_e82", busy, 1);
      @(negedge clk);
      chk("s4_ovf", overflow, 0);
      wait_bytes(20);
      chk_fill_bytes("s4");
      if (byte_q.size() >= 20) begin
         chk("s4_last_hdr", byte_q[18], 8'hA9);
         chk("s4_last_data", byte_q[19], 8'h99);
      end

      // Reset asserted between clock edges during DATA of byte 0
      do_reset();
      fill9();
      wr_valid = 1'b1; wr_add = 4'hF; wr_data = 8'hEE;
      @(negedge clk);
      wr_valid = 1'b0;
      @(negedge clk);
      chk("s5_pre_busy", busy, 1);
      chk("s5_pre_ovf", overflow, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("s5_tx", tx, 1);
      chk("s5_busy", busy, 0);
      chk("s5_full", full, 0);
      chk("s5_ovf", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      byte_q.delete(); start_q.delete();
      @(negedge clk);
      chk("s5_count", dut.fifo_count, 0);
      repeat (300) @(negedge clk);
      chk("s5_no_residual", byte_q.size(), 0);
      chk("s5_tx_idle", tx, 1);
      chk("frame_err", frame_err, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/wr_uart_logger.md
Name: wr_uart_logger

Overview:
- Sits directly downstream of the CPU write-back port.
- Captures each register/memory write event, meaning a 4-bit address and 8-bit data, into a small FIFO.
- Serialises each captured event as a two-byte UART frame so the board can stream CPU writes to a host.
- The CPU is never stalled. On overflow, events are dropped and flagged.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per UART bit; legal range is 2 or more.
- FIFO_DEPTH, 8, number of buffered write events; must be a power of two, 2 or more.
- ADDR_W, 4, write address width.
- DATA_W, 8, write data width.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_wr_valid  input  1  one-cycle strobe: a write occurs this cycle.
- i_wr_add  input  ADDR_W  write address, sampled when i_wr_valid=1.
- i_wr_data  input  DATA_W  write data, sampled when i_wr_valid=1.
- o_tx  output  1  UART serial line; idles high.
- o_busy  output  1  high while a frame is being transmitted (state is not IDLE).
- o_full  output  1  FIFO count equals FIFO_DEPTH.
- o_overflow  output  1  sticky: at least one write event was dropped.

Behaviour:
- Reset (i_reset=0, asynchronous): o_tx=1, o_busy=0, o_full=0, o_overflow=0. FIFO is emptied, FSM goes to IDLE, all counters are 0.
- Reset asserted mid-frame: the frame is aborted immediately and o_tx returns to 1 with no glitch low.
- Push rule: on an edge with i_wr_valid=1, the entry {i_wr_add, i_wr_data} is written if the FIFO is not full, OR if a pop occurs on the same edge.
  - Same-edge push and pop when full: count stays at FIFO_DEPTH.
- Drop rule: i_wr_valid=1 while full with no pop on that edge. The event is discarded, o_overflow is set from the next cycle, and it stays set until reset.
- Pop rule: FSM in IDLE with count>0 at an edge. The head entry is popped and latched into the shift register, and the FSM enters START on that edge.
- Latency: a write strobed at edge N into an empty, idle block drives o_tx low from edge N+1.
- Frame format: byte 0 = {4'hA, addr}, byte 1 = data.
  - Each byte is 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1). No parity.
  - Each bit is held exactly CLKS_PER_BIT cycles.
- FSM states:
  - IDLE: o_tx=1. If count>0, pop and go to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits via a 3-bit bit index, then STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. Then, if the byte index is 0, set byte index to 1, load the data byte and go to START with no gap. Otherwise go to IDLE.
- Full event timing: 20*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the final stop bit.
  - At least one IDLE cycle (o_tx=1) separates consecutive events.
- o_busy=1 in every state other than IDLE.
- o_full is a combinational decode of the registered count.
- Count width is log2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package holds:
  - the frame header nibble constant (4'hA);
  - the state enum (IDLE, START, DATA, STOP);
  - the bit-count constants (8 data bits, 10 bits per byte).
- One natural sub-module, wr_event_fifo: a synchronous FIFO with push, pop, full, empty and count, using the same async active-low reset.
- The UART FSM, baud counter and overflow flag stay in wr_uart_logger.

Test Plan:
- Single event: CLKS_PER_BIT=4; after reset, strobe addr=3, data=8'h5C at edge 0.
  - Required: o_tx low from edge 1.
  - Decoded bytes are 8'hA3 then 8'h5C, LSB first, 4 cycles per bit.
  - o_busy is high for 80 cycles, then o_tx=1 and o_busy=0.
- Fill without loss: 9 back-to-back strobes at edges 0-8 with addr=i, data=8'h10+i.
  - Required: after edge 8 count=8, o_full=1, o_overflow=0.
  - All 9 events are later received in order.
- Overflow: continue the previous scenario with a 10th strobe at edge 9 (full, no pop).
  - Required: o_overflow=1 from edge 10 and the 10th event is never transmitted.
  - o_overflow stays 1 after the FIFO drains.
- Simultaneous push and pop: FIFO holds 8 entries, and a strobe coincides with the IDLE pop edge.
  - Required: the entry is accepted, count stays 8, and no overflow occurs.
- Reset mid-frame: assert i_reset=0 during DATA of byte 0.
  - Required: o_tx=1, o_busy=0, o_full=0, o_overflow=0 immediately, without waiting for a clock edge.
  - After release, the FIFO is empty and no residual frame appears.
- Inter-byte gap: two queued events.
  - Required: no idle between byte 0's stop bit and byte 1's start bit.
  - Exactly one idle-high cycle between event 1's final stop bit and event 2's start bit.
